// File: rtl/pd_tally_pkg.sv
// Shared types for the PD tally block: sample/result records and the window FSM states.
// Optional early-close support is selected with PD_TALLY_FLUSH_EN.
package pd_pkg;
  localparam int DATA_W_DEF  = 4;
  localparam int WIN_LEN_DEF = 16;
  localparam int CNT_W_DEF   = $clog2(WIN_LEN_DEF + 1);

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic                  p;
    logic                  d;
  } pd_sample_t;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} pd_tally_state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]  p_cnt;
    logic [CNT_W_DEF-1:0]  d_cnt;
    logic [CNT_W_DEF-1:0]  both_cnt;
    logic [DATA_W_DEF-1:0] max_p;
    logic                  max_p_vld;
`ifdef PD_TALLY_FLUSH_EN
    logic [CNT_W_DEF-1:0]  len;
`endif
  } pd_result_t;
endpackage

// File: rtl/pd_tally_acc.sv
// Next-value logic for the window accumulators: hit counts plus running max of P=1 codes.
module pd_tally_acc import pd_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              take,
  input  logic [DATA_W-1:0] a,
  input  logic              p,
  input  logic              d,
  input  logic [CNT_W-1:0]  p_cur,
  input  logic [CNT_W-1:0]  d_cur,
  input  logic [CNT_W-1:0]  both_cur,
  input  logic [DATA_W-1:0] max_cur,
  input  logic              maxv_cur,
  output logic [CNT_W-1:0]  p_nxt,
  output logic [CNT_W-1:0]  d_nxt,
  output logic [CNT_W-1:0]  both_nxt,
  output logic [DATA_W-1:0] max_nxt,
  output logic              maxv_nxt
);
  always_comb begin
    p_nxt    = p_cur;
    d_nxt    = d_cur;
    both_nxt = both_cur;
    max_nxt  = max_cur;
    maxv_nxt = maxv_cur;
    if (take) begin
      p_nxt    = p_cur + CNT_W'(p);
      d_nxt    = d_cur + CNT_W'(d);
      both_nxt = both_cur + CNT_W'(p & d);
      // A=0 with P=1 still marks the max valid; the classifier upstream is trusted, not filtered.
      if (p && (!maxv_cur || a > max_cur)) begin
        max_nxt  = a;
        maxv_nxt = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pd_tally.sv
// Windowed statistics over PD classifier samples; one result record per WIN_LEN samples.
// Defining PD_TALLY_FLUSH_EN adds a flush input (early close) and an out_len output.
module pd_tally import pd_pkg::*; #(
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int WIN_LEN = WIN_LEN_DEF,
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_p,
  input  logic              in_d,
`ifdef PD_TALLY_FLUSH_EN
  input  logic              flush,
  output logic [CNT_W-1:0]  out_len,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_p_cnt,
  output logic [CNT_W-1:0]  out_d_cnt,
  output logic [CNT_W-1:0]  out_both_cnt,
  output logic [DATA_W-1:0] out_max_p,
  output logic              out_max_p_vld
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  pd_tally_state_e state_q, state_d;
  logic [CNT_W-1:0]  smp_cnt_q, smp_cnt_d, smp_nxt;
  logic [CNT_W-1:0]  p_acc_q, p_acc_d, d_acc_q, d_acc_d, both_acc_q, both_acc_d;
  logic [DATA_W-1:0] max_acc_q, max_acc_d;
  logic              maxv_acc_q, maxv_acc_d;
  logic [CNT_W-1:0]  p_nxt, d_nxt, both_nxt;
  logic [DATA_W-1:0] max_nxt;
  logic              maxv_nxt;
  logic [CNT_W-1:0]  out_p_cnt_q, out_p_cnt_d, out_d_cnt_q, out_d_cnt_d;
  logic [CNT_W-1:0]  out_both_cnt_q, out_both_cnt_d, out_len_q, out_len_d;
  logic [DATA_W-1:0] out_max_p_q, out_max_p_d;
  logic              out_max_p_vld_q, out_max_p_vld_d;
  logic              accept, close;

  assign accept  = in_valid && in_ready;
  assign smp_nxt = smp_cnt_q + CNT_W'(accept);

`ifdef PD_TALLY_FLUSH_EN
  assign close = (accept && smp_cnt_q == LAST_IDX) ||
                 (flush && in_ready && (smp_cnt_q != '0 || accept));
  assign out_len = out_len_q;
`else
  assign close = accept && smp_cnt_q == LAST_IDX;
`endif

  pd_tally_acc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_acc (
    .take     (accept),
    .a        (in_a),
    .p        (in_p),
    .d        (in_d),
    .p_cur    (p_acc_q),
    .d_cur    (d_acc_q),
    .both_cur (both_acc_q),
    .max_cur  (max_acc_q),
    .maxv_cur (maxv_acc_q),
    .p_nxt    (p_nxt),
    .d_nxt    (d_nxt),
    .both_nxt (both_nxt),
    .max_nxt  (max_nxt),
    .maxv_nxt (maxv_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ACCUM;
      smp_cnt_q       <= '0;
      p_acc_q         <= '0;
      d_acc_q         <= '0;
      both_acc_q      <= '0;
      max_acc_q       <= '0;
      maxv_acc_q      <= 1'b0;
      out_p_cnt_q     <= '0;
      out_d_cnt_q     <= '0;
      out_both_cnt_q  <= '0;
      out_max_p_q     <= '0;
      out_max_p_vld_q <= 1'b0;
      out_len_q       <= '0;
    end else begin
      state_q         <= state_d;
      smp_cnt_q       <= smp_cnt_d;
      p_acc_q         <= p_acc_d;
      d_acc_q         <= d_acc_d;
      both_acc_q      <= both_acc_d;
      max_acc_q       <= max_acc_d;
      maxv_acc_q      <= maxv_acc_d;
      out_p_cnt_q     <= out_p_cnt_d;
      out_d_cnt_q     <= out_d_cnt_d;
      out_both_cnt_q  <= out_both_cnt_d;
      out_max_p_q     <= out_max_p_d;
      out_max_p_vld_q <= out_max_p_vld_d;
      out_len_q       <= out_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  // On close the record captures the accumulators including the sample taken on this edge.
  always_comb begin
    smp_cnt_d       = smp_nxt;
    p_acc_d         = p_nxt;
    d_acc_d         = d_nxt;
    both_acc_d      = both_nxt;
    max_acc_d       = max_nxt;
    maxv_acc_d      = maxv_nxt;
    out_p_cnt_d     = out_p_cnt_q;
    out_d_cnt_d     = out_d_cnt_q;
    out_both_cnt_d  = out_both_cnt_q;
    out_max_p_d     = out_max_p_q;
    out_max_p_vld_d = out_max_p_vld_q;
    out_len_d       = out_len_q;
    if (close) begin
      out_p_cnt_d     = p_nxt;
      out_d_cnt_d     = d_nxt;
      out_both_cnt_d  = both_nxt;
      out_max_p_d     = max_nxt;
      out_max_p_vld_d = maxv_nxt;
      out_len_d       = smp_nxt;
      smp_cnt_d       = '0;
      p_acc_d         = '0;
      d_acc_d         = '0;
      both_acc_d      = '0;
      max_acc_d       = '0;
      maxv_acc_d      = 1'b0;
    end
  end

  assign out_p_cnt     = out_p_cnt_q;
  assign out_d_cnt     = out_d_cnt_q;
  assign out_both_cnt  = out_both_cnt_q;
  assign out_max_p     = out_max_p_q;
  assign out_max_p_vld = out_max_p_vld_q;
endmodule
